// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types and constants for the CSR/CLINT Wishbone arbiter.
package wb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} arb_state_t;
  typedef enum logic {P0, P1} requester_id_t;
  localparam logic [63:0] ABORT_DATA = '1;
endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: single-transfer Wishbone bundle; dat_o_p flows primary->secondary, dat_o_s the reverse.
interface wishbone_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TGD_SIZE = 4
);
  logic cyc, stb, we, ack;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE/8-1:0] sel;
  logic [TGD_SIZE-1:0] tgd;
  logic [DATA_SIZE-1:0] dat_o_p, dat_o_s;
  modport primary (output cyc, stb, we, addr, sel, tgd, dat_o_p, input ack, dat_o_s);
  modport secondary (input cyc, stb, we, addr, sel, tgd, dat_o_p, output ack, dat_o_s);
endinterface

// File: rtl/wb_rr_pointer.sv
// wb_rr_pointer: last-served pointer and two-way round-robin grant decision.
module wb_rr_pointer
  import wb_arbiter_pkg::*;
(
  input logic clock,
  input logic reset,
  input logic req0,
  input logic req1,
  input logic update,
  input requester_id_t served,
  output requester_id_t win
);
  requester_id_t last;
  always_ff @(posedge clock or negedge reset)
    if (!reset) last <= P1;
    else if (update) last <= served;
  assign win = (req0 & req1) ? (last == P0 ? P1 : P0) : (req0 ? P0 : P1);
endmodule

// File: rtl/wb_csr_arbiter.sv
// wb_csr_arbiter: round-robin arbiter of two Wishbone requesters onto the CSR/CLINT slave.
// Watchdog abort is built only when WB_CSR_ARBITER_TIMEOUT_EN is defined.
module wb_csr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clock,
  input logic reset,
  wishbone_if.secondary wb_if_p0,
  wishbone_if.secondary wb_if_p1,
  wishbone_if.primary wb_if_m,
  output logic timeout_pulse,
  output logic timeout_sticky,
  input logic timeout_clear
);
  arb_state_t state, state_n;
  requester_id_t grant, win;
  logic p0_req, p1_req, g1, busy, abort, g_cyc, timeout, update, resp_ack;
  logic [ADDR_SIZE-1:0] g_addr;
  logic [DATA_SIZE-1:0] g_dat, resp_dat;
  logic [DATA_SIZE/8-1:0] g_sel;
  assign p0_req = wb_if_p0.cyc & wb_if_p0.stb;
  assign p1_req = wb_if_p1.cyc & wb_if_p1.stb;
  assign g1 = grant == P1;
  assign busy = state == BUSY;
  assign abort = state == ABORT;
  assign g_cyc = g1 ? wb_if_p1.cyc : wb_if_p0.cyc;
  wb_rr_pointer u_ptr (
    .clock(clock),
    .reset(reset),
    .req0(p0_req),
    .req1(p1_req),
    .update(update),
    .served(grant),
    .win(win)
  );
  always_comb begin
    state_n = state;
    update = 1'b0;
    if (state == IDLE) state_n = (p0_req | p1_req) ? BUSY : IDLE;
    else if (abort || wb_if_m.ack || !g_cyc) begin
      state_n = IDLE;
      update = 1'b1;
    end else if (timeout) state_n = ABORT;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= P0;
    end else begin
      state <= state_n;
      if (state == IDLE && (p0_req | p1_req)) grant <= win;
    end
  assign g_addr = g1 ? wb_if_p1.addr : wb_if_p0.addr;
  assign g_dat = g1 ? wb_if_p1.dat_o_p : wb_if_p0.dat_o_p;
  assign g_sel = g1 ? wb_if_p1.sel : wb_if_p0.sel;
  assign wb_if_m.cyc = busy & g_cyc;
  assign wb_if_m.stb = busy & (g1 ? wb_if_p1.stb : wb_if_p0.stb);
  assign wb_if_m.we = busy & (g1 ? wb_if_p1.we : wb_if_p0.we);
  assign wb_if_m.addr = g_addr;
  assign wb_if_m.dat_o_p = g_dat;
  assign wb_if_m.sel = g_sel;
  assign wb_if_m.tgd = g1 ? wb_if_p1.tgd : wb_if_p0.tgd;
  // Only the granted requester ever sees a response; an abort answers with all-ones.
  assign resp_ack = busy ? wb_if_m.ack : abort;
  assign resp_dat = busy ? wb_if_m.dat_o_s : abort ? ABORT_DATA[DATA_SIZE-1:0] : '0;
  assign wb_if_p0.ack = resp_ack & ~g1;
  assign wb_if_p1.ack = resp_ack & g1;
  assign wb_if_p0.dat_o_s = g1 ? '0 : resp_dat;
  assign wb_if_p1.dat_o_s = g1 ? resp_dat : '0;
`ifdef WB_CSR_ARBITER_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic sticky;
  assign timeout = wd_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wd_cnt <= '0;
      sticky <= 1'b0;
    end else begin
      wd_cnt <= busy ? wd_cnt + 16'(!wb_if_m.ack) : '0;
      sticky <= abort | (sticky & ~timeout_clear);
    end
  assign timeout_pulse = abort;
  assign timeout_sticky = sticky;
`else
  logic [16:0] unused_wd;
  assign unused_wd = {timeout_clear, 16'(TIMEOUT_CYCLES)};
  assign timeout = 1'b0;
  assign timeout_pulse = 1'b0;
  assign timeout_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_wb_csr_arbiter.sv
// tb_wb_csr_arbiter: directed bench with a response scoreboard for wb_csr_arbiter.
module tb_wb_csr_arbiter;
  typedef struct {
    int port;
    logic [31:0] data;
  } resp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic timeout_clear = 1'b0;
  logic timeout_pulse, timeout_sticky;
  int checks = 0;
  int failures = 0;
  resp_t sb_q[$];
  wishbone_if #(.DATA_SIZE(32), .ADDR_SIZE(32)) p0 ();
  wishbone_if #(.DATA_SIZE(32), .ADDR_SIZE(32)) p1 ();
  wishbone_if #(.DATA_SIZE(32), .ADDR_SIZE(32)) m ();
  wb_csr_arbiter #(.DATA_SIZE(32), .ADDR_SIZE(32), .TIMEOUT_CYCLES(8)) dut (
    .clock(clk),
    .reset(reset),
    .wb_if_p0(p0.secondary),
    .wb_if_p1(p1.secondary),
    .wb_if_m(m.primary),
    .timeout_pulse(timeout_pulse),
    .timeout_sticky(timeout_sticky),
    .timeout_clear(timeout_clear)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic sample();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int p, input logic on, input logic we, input logic [31:0] addr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (p == 0) begin
      p0.cyc = on; p0.stb = on; p0.we = we; p0.addr = addr; p0.dat_o_p = dat; p0.sel = sel; p0.tgd = 4'h1;
    end else begin
      p1.cyc = on; p1.stb = on; p1.we = we; p1.addr = addr; p1.dat_o_p = dat; p1.sel = sel; p1.tgd = 4'h2;
    end
  endtask
  task automatic target(input logic ack, input logic [31:0] dat);
    m.ack = ack;
    m.dat_o_s = dat;
  endtask
  task automatic expect_ack(input string tag);
    resp_t e;
    int port;
    port = (p0.ack === 1'b1) ? 0 : (p1.ack === 1'b1) ? 1 : -1;
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '{-2, 32'h0};
    chk({tag, "_port"}, 32'(port), 32'(e.port));
    chk({tag, "_data"}, port == 1 ? p1.dat_o_s : p0.dat_o_s, e.data);
    chk({tag, "_other"}, port == 1 ? {p0.ack, p0.dat_o_s} : {p1.ack, p1.dat_o_s}, 32'h0);
  endtask
  task automatic do_reset();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask
  initial begin
    logic bad;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    target(0, 0);
    sample();
    chk("rst_m_cyc", {m.cyc, m.stb, m.we}, 0);
    chk("rst_acks", {p0.ack, p1.ack}, 0);
    chk("rst_timeout", {timeout_pulse, timeout_sticky}, 0);
    step();
    reset = 1'b1;
    // single p0 read, target acks on its second cycle
    step();
    drive(0, 1, 0, 32'hF0003800, 0, 4'hF);
    sb_q.push_back('{0, 32'h12345678});
    sample();
    chk("rd_idle_cyc", m.cyc, 0);
    step();
    sample();
    chk("rd_busy_cyc", {m.cyc, m.stb, m.we}, 3'b110);
    chk("rd_addr", m.addr, 32'hF0003800);
    chk("rd_no_ack_yet", p0.ack, 0);
    step();
    target(1, 32'h12345678);
    sample();
    expect_ack("rd");
    step();
    drive(0, 0, 0, 0, 0, 0);
    target(0, 0);
    sample();
    chk("rd_done_cyc", m.cyc, 0);
    // simultaneous requests straight after reset
    do_reset();
    drive(0, 1, 0, 32'h10, 0, 4'hF);
    drive(1, 1, 0, 32'h20, 0, 4'hF);
    sb_q.push_back('{0, 32'hAAAA0001});
    sb_q.push_back('{1, 32'hBBBB0002});
    step();
    target(1, 32'hAAAA0001);
    sample();
    chk("tie_first_addr", m.addr, 32'h10);
    expect_ack("tie_p0");
    step();
    drive(0, 0, 0, 0, 0, 0);
    target(0, 0);
    sample();
    chk("tie_gap_cyc", m.cyc, 0);
    step();
    target(1, 32'hBBBB0002);
    sample();
    chk("tie_second_addr", m.addr, 32'h20);
    expect_ack("tie_p1");
    step();
    drive(1, 0, 0, 0, 0, 0);
    target(0, 0);
    // p1 write
    step();
    drive(1, 1, 1, 32'hF0003800, 32'h000000A5, 4'h3);
    sb_q.push_back('{1, 32'h0});
    step();
    target(1, 32'h0);
    sample();
    chk("wr_we", {m.cyc, m.we}, 2'b11);
    chk("wr_dat", m.dat_o_p, 32'h000000A5);
    chk("wr_sel_tgd", {m.sel, m.tgd}, {4'h3, 4'h2});
    chk("wr_addr", m.addr, 32'hF0003800);
    expect_ack("wr");
    step();
    drive(1, 0, 0, 0, 0, 0);
    target(0, 0);
    // p0 abandons its cycle, next tie goes to p1
    step();
    drive(0, 1, 0, 32'h30, 0, 4'hF);
    step();
    sample();
    chk("drop_busy_cyc", m.cyc, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    sample();
    chk("drop_m_cyc", {m.cyc, p0.ack}, 0);
    step();
    drive(0, 1, 0, 32'h40, 0, 4'hF);
    drive(1, 1, 0, 32'h44, 0, 4'hF);
    sb_q.push_back('{1, 32'hD1D1D1D1});
    sb_q.push_back('{0, 32'hD0D0D0D0});
    sample();
    chk("drop_idle_cyc", m.cyc, 0);
    step();
    target(1, 32'hD1D1D1D1);
    sample();
    chk("drop_next_addr", m.addr, 32'h44);
    expect_ack("drop_p1");
    step();
    drive(1, 0, 0, 0, 0, 0);
    target(0, 0);
    step();
    target(1, 32'hD0D0D0D0);
    sample();
    expect_ack("drop_p0");
    step();
    drive(0, 0, 0, 0, 0, 0);
    target(0, 0);
    // asynchronous reset while a transfer is in flight
    step();
    drive(0, 1, 0, 32'h50, 0, 4'hF);
    step();
    #2;
    target(1, 32'h5555AAAA);
    reset = 1'b0;
    #1;
    chk("arst_m_cyc", {m.cyc, m.stb, m.we}, 0);
    chk("arst_ack", {p0.ack, p1.ack, p0.dat_o_s}, 0);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    target(0, 0);
`ifdef WB_CSR_ARBITER_TIMEOUT_EN
    // target never acks: abort after eight busy cycles
    step();
    drive(0, 1, 0, 32'h60, 0, 4'hF);
    sb_q.push_back('{0, 32'hFFFFFFFF});
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      sample();
      bad |= m.cyc !== 1'b1 || p0.ack !== 1'b0 || timeout_pulse !== 1'b0;
    end
    chk("to_busy_window", bad, 0);
    step();
    timeout_clear = 1'b1;
    sample();
    expect_ack("to_abort");
    chk("to_pulse", timeout_pulse, 1);
    chk("to_abort_m_cyc", m.cyc, 0);
    step();
    timeout_clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    sample();
    chk("to_after", {timeout_pulse, timeout_sticky, p0.ack}, 3'b010);
    step();
    step();
    sample();
    chk("to_sticky_hold", timeout_sticky, 1);
    timeout_clear = 1'b1;
    step();
    timeout_clear = 1'b0;
    sample();
    chk("to_sticky_clr", timeout_sticky, 0);
    // ack lands on the exact timeout cycle
    step();
    drive(0, 1, 0, 32'h70, 0, 4'hF);
    sb_q.push_back('{0, 32'hCAFE0008});
    for (int i = 0; i < 7; i++) step();
    step();
    target(1, 32'hCAFE0008);
    sample();
    expect_ack("edge_ack");
    chk("edge_pulse", timeout_pulse, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    target(0, 0);
    sample();
    chk("edge_after", {timeout_pulse, m.cyc}, 0);
    step();
    sample();
    chk("edge_sticky", timeout_sticky, 0);
`else
    // without the watchdog a silent target simply stalls the grant
    step();
    drive(0, 1, 0, 32'h60, 0, 4'hF);
    sb_q.push_back('{0, 32'h600D600D});
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      sample();
      bad |= m.cyc !== 1'b1 || p0.ack !== 1'b0 || timeout_pulse !== 1'b0 || timeout_sticky !== 1'b0;
    end
    chk("nowd_stall", bad, 0);
    step();
    target(1, 32'h600D600D);
    sample();
    expect_ack("nowd_ack");
    step();
    drive(0, 0, 0, 0, 0, 0);
    target(0, 0);
    sample();
    chk("nowd_timeout", {timeout_pulse, timeout_sticky, m.cyc}, 0);
`endif
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_csr_arbiter.md
WB_CSR_ARBITER -- requirements
Module: wb_csr_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 32, SHALL set data width of all three ports.
REQ-002 Parameter ADDR_SIZE, default 32, SHALL set address width of all three ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 2..65535, SHALL set the watchdog limit in clock cycles.
REQ-004 Port `clock` SHALL be an input, 1 bit, and the single clock; all state SHALL be on its rising edge.
REQ-005 Port `reset` SHALL be an input, 1 bit, asynchronous, active-low reset.
REQ-006 Port `wb_if_p0` SHALL be a wishbone_if.secondary, the core data requester.
REQ-007 Port `wb_if_p1` SHALL be a wishbone_if.secondary, the debug/DMA requester.
REQ-008 Port `wb_if_m` SHALL be a wishbone_if.primary, driving the shared csr_and_clint slave.
REQ-009 Port `timeout_pulse` SHALL be an output, 1 bit, high for one cycle when a watchdog abort occurs.
REQ-010 Port `timeout_sticky` SHALL be an output, 1 bit, set on abort and held until `timeout_clear`.
REQ-011 Port `timeout_clear` SHALL be an input, 1 bit, a synchronous clear of `timeout_sticky`.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and ABORT.
REQ-013 A requester SHALL be pending when its cyc and stb are both high.
REQ-014 In IDLE with any requester pending:
- the FSM SHALL register the grant and go to BUSY next cycle;
- granted-address to target cyc latency SHALL be 1 cycle.
REQ-015 On simultaneous requests, the requester not served last SHALL win; the last-served pointer SHALL reset to p1, so p0 wins the first tie.
REQ-016 In BUSY, the granted requester's cyc, stb, we, addr, sel, tgd and dat_o_p SHALL be forwarded combinationally to wb_if_m.
REQ-017 In all states other than BUSY, wb_if_m cyc, stb and we SHALL be 0.
REQ-018 In BUSY, target ack SHALL be forwarded combinationally, together with dat_o_s, to the granted requester only.
REQ-019 On target ack in BUSY:
- the FSM SHALL return to IDLE;
- the last-served pointer SHALL update;
- each grant SHALL cover exactly one transfer.
REQ-020 A non-granted requester SHALL see ack=0 and dat_o_s=0.
REQ-021 If the granted requester drops cyc in BUSY, the FSM SHALL go to IDLE next cycle, with no ack and the pointer updated.
REQ-022 A 16-bit watchdog counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 without ack, the FSM SHALL enter ABORT.
REQ-024 If target ack and the timeout condition occur in the same cycle, the ack SHALL win and ABORT SHALL NOT be entered.
REQ-025 For its single cycle, ABORT SHALL:
- drive ack=1 and dat_o_s=all-ones to the granted requester;
- pulse timeout_pulse;
- set timeout_sticky;
- return to IDLE.
REQ-026 If timeout_clear and a set occur in the same cycle, the set SHALL win.

Reset
REQ-027 While reset is low:
- the state SHALL be IDLE;
- the pointer SHALL be p1;
- the counter SHALL be 0;
- timeout_pulse and timeout_sticky SHALL be 0;
- all wb_if_m strobes and all requester acks SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no ack issued.

Configuration
REQ-029 Macro WB_CSR_ARBITER_TIMEOUT_EN SHALL control the watchdog.
- Defined: watchdog per REQ-022..026.
- Undefined: no counter and no ABORT state; BUSY waits indefinitely; timeout_pulse and timeout_sticky SHALL be tied to 0.

Structure
REQ-030 Package wb_arbiter_pkg SHALL hold:
- typedef arb_state_t {IDLE, BUSY, ABORT};
- constant ABORT_DATA (all-ones);
- typedef requester_id_t.
REQ-031 One sub-module, wb_rr_pointer, SHALL hold the round-robin pointer and grant decision; all other logic SHALL stay in wb_csr_arbiter.

Verification
REQ-032 Single p0 read at 0xF0003800, target acks on its 2nd cycle -> p0 ack on cycle 3 after request with target data; p1 ack stays 0.
REQ-033 p0 and p1 request in the same cycle after reset -> p0 served first; after its ack, p1 is granted one IDLE cycle later.
REQ-034 p1 write 0x000000A5 to 0xF0003800 -> wb_if_m we=1, dat_o_p=0x000000A5, sel forwarded; p0 sees no ack.
REQ-035 TIMEOUT_CYCLES=8, target never acks ->
- ABORT after 8 BUSY cycles;
- p0 ack with 0xFFFFFFFF;
- timeout_pulse for 1 cycle;
- sticky stays 1 until timeout_clear.
REQ-036 Target ack on the exact timeout cycle -> normal ack, no pulse, sticky stays 0.
REQ-037 Reset pulsed low in BUSY; separately, p0 drops cyc in BUSY -> IDLE, no ack, wb_if_m cyc=0, next arbitration favours p1.
